hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits alongside the IF/ID/EX pipeline registers, directly upstream of the EX-stage operand forwarding logic. It decides when IF/ID and ID/EX advance, hold or bubble, so forwarding only ever sees legal producer/consumer pairs.
- Handles three hazard classes: load-use bubbles, control-redirect flushes, and I/D-cache wait stalls. It latches early cache responses so that none is lost while the other cache is still busy.

Parameters:
- PERF_CNT_WIDTH, 32, width of each performance counter (used only with HAZARD_PERF_CNT_EN).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- IFID_rs1  in  5  rs1 of the instruction in ID.
- IFID_rs2  in  5  rs2 of the instruction in ID.
- IFID_uses_rs1  in  1  ID instruction reads rs1.
- IFID_uses_rs2  in  1  ID instruction reads rs2.
- IDEX_rd  in  5  rd of the instruction in EX.
- IDEX_mem_read  in  1  EX instruction is a load.
- EX_redirect  in  1  EX resolved a taken branch, jal or jalr.
- imem_read  in  1  I-cache request active.
- imem_resp  in  1  I-cache response, one-cycle pulse.
- dmem_req  in  1  MEM stage has a load or store outstanding.
- dmem_resp  in  1  D-cache response, one-cycle pulse.
- pc_load  out  1  PC register enable.
- IFID_load  out  1  IF/ID enable.
- IDEX_load  out  1  ID/EX enable.
- EXMEM_load  out  1  EX/MEM enable.
- MEMWB_load  out  1  MEM/WB enable.
- IFID_flush  out  1  IF/ID loads a NOP (valid only with IFID_load).
- IDEX_flush  out  1  ID/EX loads a bubble: control bits zeroed, load_reg=0.
- perf_mem_stall  out  PERF_CNT_WIDTH  cache-stall cycle count.
- perf_load_use  out  PERF_CNT_WIDTH  load-use bubble count.
- perf_redirect  out  PERF_CNT_WIDTH  redirect flush count.

Behaviour:
- State registers: ic_done_q and dc_done_q. Reset (async, rst=1) clears both; perf counters also reset to 0.
- ic_busy = imem_read & ~imem_resp & ~ic_done_q.
- dc_busy = dmem_req & ~dmem_resp & ~dc_done_q.
- mem_stall = ic_busy | dc_busy.
- Done-flag update, every rising clk edge:
  - If mem_stall=1: ic_done_q |= imem_resp and dc_done_q |= dmem_resp.
  - Else both flags clear (the pipeline advances, so the responses are consumed).
  - Simultaneous imem_resp and dmem_resp with mem_stall=0: no flag is set and the pipeline advances the same cycle.
- Outputs are combinational from inputs and state. All five *_load outputs are 0 while rst is held. Priority order, highest first:
  1. mem_stall=1: all *_load=0, both flushes=0. The whole pipe freezes; EX_redirect and the load-use check are ignored that cycle.
  2. EX_redirect=1: all *_load=1, IFID_flush=1, IDEX_flush=1. Two wrong-path instructions are squashed. A load-use hazard detected the same cycle is ignored, because the ID instruction is wrong-path.
  3. Load-use: IDEX_mem_read & IDEX_rd!=0 & ((IFID_uses_rs1 & IFID_rs1==IDEX_rd) | (IFID_uses_rs2 & IFID_rs2==IDEX_rd)).
     - Response: pc_load=0, IFID_load=0, IDEX_load=1 with IDEX_flush=1, EXMEM_load=1, MEMWB_load=1.
     - Exactly one bubble per hazard. The next cycle IDEX holds the bubble (mem_read=0), so the hazard cannot re-trigger.
  4. Otherwise: all *_load=1, both flushes=0.
- rd=x0 never causes a load-use stall, even when rs1 or rs2 is 0.
- A redirect that arrives during mem_stall produces no flush until the stall ends. It is not lost, because ID/EX is frozen and EX_redirect stays asserted.
- Reset asserted mid-stall: the done flags clear immediately and no stale response is carried over.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - perf_mem_stall increments on every cycle with mem_stall=1.
  - perf_load_use increments on each cycle where rule 3 fires.
  - perf_redirect increments on each cycle where rule 2 fires.
  - All counters saturate at all-ones (no wrap) and reset asynchronously to 0.
- Undefined: the counter logic is omitted and all perf_* outputs are tied to 0. Ports remain so the top level is unchanged.

Test Plan:
- Load-use: IDEX_mem_read=1, IDEX_rd=5, IFID_rs2=5, IFID_uses_rs2=1 -> one cycle with pc_load=0, IFID_load=0, IDEX_flush=1. Next cycle (IDEX_mem_read=0) all loads=1; perf_load_use=1.
- x0 / unused operand: IDEX_rd=0 matching IFID_rs1=0, and separately IDEX_rd=7 with IFID_rs1=7 but IFID_uses_rs1=0 -> no stall either case.
- Redirect beats load-use: EX_redirect=1 together with a load-use match -> all loads=1, IFID_flush=1, IDEX_flush=1, perf_load_use unchanged, perf_redirect +1.
- Split cache completion: dmem_req=1 and imem_read=1; imem_resp at cycle 2, dmem_resp at cycle 5 -> mem_stall held through cycles 0-4, ic_done_q=1 from cycle 3, pipe advances at cycle 5, both flags 0 at cycle 6; perf_mem_stall=5.
- Redirect during stall: EX_redirect=1 with dc_busy for 3 cycles -> no flush for those 3 cycles; flush on the cycle dmem_resp arrives.
- Async reset mid-stall: rst pulsed between clk edges while ic_done_q=1 -> flags and counters are 0 immediately; all *_load=0 while rst is high.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use/redirect/cache-stall pipeline control, perf counters under HAZARD_PERF_CNT_EN
module hazard_control_unit #(
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                IFID_rs1,
  input  logic [4:0]                IFID_rs2,
  input  logic                      IFID_uses_rs1,
  input  logic                      IFID_uses_rs2,
  input  logic [4:0]                IDEX_rd,
  input  logic                      IDEX_mem_read,
  input  logic                      EX_redirect,
  input  logic                      imem_read,
  input  logic                      imem_resp,
  input  logic                      dmem_req,
  input  logic                      dmem_resp,
  output logic                      pc_load,
  output logic                      IFID_load,
  output logic                      IDEX_load,
  output logic                      EXMEM_load,
  output logic                      MEMWB_load,
  output logic                      IFID_flush,
  output logic                      IDEX_flush,
  output logic [PERF_CNT_WIDTH-1:0] perf_mem_stall,
  output logic [PERF_CNT_WIDTH-1:0] perf_load_use,
  output logic [PERF_CNT_WIDTH-1:0] perf_redirect
);
  logic ic_done_q, dc_done_q, ic_busy, dc_busy, mem_stall, load_use, adv;
  always_comb begin
    ic_busy    = imem_read & ~imem_resp & ~ic_done_q;
    dc_busy    = dmem_req & ~dmem_resp & ~dc_done_q;
    mem_stall  = ic_busy | dc_busy;
    load_use   = IDEX_mem_read & (IDEX_rd != 5'd0) &
                 ((IFID_uses_rs1 & (IFID_rs1 == IDEX_rd)) | (IFID_uses_rs2 & (IFID_rs2 == IDEX_rd)));
    adv        = ~rst & ~mem_stall;
    pc_load    = adv & (EX_redirect | ~load_use);
    IFID_load  = adv & (EX_redirect | ~load_use);
    IDEX_load  = adv;
    EXMEM_load = adv;
    MEMWB_load = adv;
    IFID_flush = adv & EX_redirect;
    IDEX_flush = adv & (EX_redirect | load_use);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      ic_done_q <= mem_stall ? (ic_done_q | imem_resp) : 1'b0;
      dc_done_q <= mem_stall ? (dc_done_q | dmem_resp) : 1'b0;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_CNT_WIDTH-1:0] ONE = PERF_CNT_WIDTH'(1);
  logic inc_ms, inc_lu, inc_rd;
  always_comb begin
    inc_ms = mem_stall & (perf_mem_stall != '1);
    inc_lu = ~mem_stall & ~EX_redirect & load_use & (perf_load_use != '1);
    inc_rd = ~mem_stall & EX_redirect & (perf_redirect != '1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mem_stall <= '0;
      perf_load_use  <= '0;
      perf_redirect  <= '0;
    end else begin
      perf_mem_stall <= inc_ms ? perf_mem_stall + ONE : perf_mem_stall;
      perf_load_use  <= inc_lu ? perf_load_use + ONE : perf_load_use;
      perf_redirect  <= inc_rd ? perf_redirect + ONE : perf_redirect;
    end
  end
`else
  assign perf_mem_stall = '0;
  assign perf_load_use  = '0;
  assign perf_redirect  = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] ADV = 7'b11111_00;
  localparam logic [6:0] FRZ = 7'b00000_00;
  localparam logic [6:0] RED = 7'b11111_11;
  localparam logic [6:0] LU  = 7'b00111_01;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic IFID_uses_rs1, IFID_uses_rs2, IDEX_mem_read, EX_redirect;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load, IFID_flush, IDEX_flush;
  logic [31:0] perf_mem_stall, perf_load_use, perf_redirect;
  logic [6:0] outs;
  logic [31:0] e_ms, e_lu, e_rd;
  int errors = 0, checks = 0;
  assign outs = {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load, IFID_flush, IDEX_flush};
  hazard_control_unit #(.PERF_CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_uses_rs1(IFID_uses_rs1), .IFID_uses_rs2(IFID_uses_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_mem_read(IDEX_mem_read), .EX_redirect(EX_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .IFID_load(IFID_load), .IDEX_load(IDEX_load),
    .EXMEM_load(EXMEM_load), .MEMWB_load(MEMWB_load),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .perf_mem_stall(perf_mem_stall), .perf_load_use(perf_load_use), .perf_redirect(perf_redirect)
  );
  always #5 clk = ~clk;
  task idle;
    IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IFID_uses_rs1 = 1'b0; IFID_uses_rs2 = 1'b0;
    IDEX_rd = 5'd0; IDEX_mem_read = 1'b0; EX_redirect = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask
  task next;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    idle();
    e_ms = 0; e_lu = 0; e_rd = 0;
    #7;
    checks++;
    if (outs !== FRZ) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, FRZ); end
    checks++;
    if ({dut.ic_done_q, dut.dc_done_q} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {dut.ic_done_q, dut.dc_done_q}); end
    checks++;
    if ({perf_mem_stall, perf_load_use, perf_redirect} !== 96'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_mem_stall, perf_load_use, perf_redirect); end
    #5 rst = 1'b0;
    #1;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL post_reset_adv got=%b exp=%b", outs, ADV); end
    next();
  endtask
  task test_load_use;
    IDEX_mem_read = 1'b1; IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_uses_rs2 = 1'b1; IFID_rs1 = 5'd3; IFID_uses_rs1 = 1'b1;
    #4;
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", outs, LU); end
    next(); e_lu++;
    IDEX_mem_read = 1'b0; IDEX_rd = 5'd0;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL lu_bubble_adv got=%b exp=%b", outs, ADV); end
    checks++;
    if (perf_load_use !== (PERF ? e_lu : 32'd0)) begin errors++; $display("FAIL lu_count got=%0d exp=%0d", perf_load_use, PERF ? e_lu : 32'd0); end
    next();
    IDEX_mem_read = 1'b1; IDEX_rd = 5'd3; IFID_rs2 = 5'd9;
    #4;
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", outs, LU); end
    next(); e_lu++;
    idle();
  endtask
  task test_no_stall;
    IDEX_mem_read = 1'b1; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_uses_rs1 = 1'b1; IFID_rs2 = 5'd0; IFID_uses_rs2 = 1'b1;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL x0_no_stall got=%b exp=%b", outs, ADV); end
    next();
    IDEX_rd = 5'd7; IFID_rs1 = 5'd7; IFID_uses_rs1 = 1'b0; IFID_rs2 = 5'd2; IFID_uses_rs2 = 1'b1;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL unused_rs1 got=%b exp=%b", outs, ADV); end
    next();
    IFID_rs1 = 5'd2; IFID_uses_rs1 = 1'b1; IFID_rs2 = 5'd7; IFID_uses_rs2 = 1'b0;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL unused_rs2 got=%b exp=%b", outs, ADV); end
    next();
    IDEX_mem_read = 1'b0; IFID_rs1 = 5'd7;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL non_load got=%b exp=%b", outs, ADV); end
    next();
    idle();
  endtask
  task test_redirect_priority;
    IDEX_mem_read = 1'b1; IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_uses_rs2 = 1'b1; EX_redirect = 1'b1;
    #4;
    checks++;
    if (outs !== RED) begin errors++; $display("FAIL redirect_beats_lu got=%b exp=%b", outs, RED); end
    next(); e_rd++;
    idle();
    #4;
    checks++;
    if (perf_load_use !== (PERF ? e_lu : 32'd0)) begin errors++; $display("FAIL redir_lu_count got=%0d exp=%0d", perf_load_use, PERF ? e_lu : 32'd0); end
    checks++;
    if (perf_redirect !== (PERF ? e_rd : 32'd0)) begin errors++; $display("FAIL redir_count got=%0d exp=%0d", perf_redirect, PERF ? e_rd : 32'd0); end
    next();
  endtask
  task test_split_cache;
    imem_read = 1'b1; dmem_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      imem_resp = (c == 2);
      dmem_resp = (c == 5);
      #4;
      checks++;
      if (outs !== (c < 5 ? FRZ : ADV)) begin errors++; $display("FAIL split_c%0d got=%b exp=%b", c, outs, c < 5 ? FRZ : ADV); end
      checks++;
      if ({dut.ic_done_q, dut.dc_done_q} !== {c >= 3, 1'b0}) begin errors++; $display("FAIL split_flags_c%0d got=%b exp=%b", c, {dut.ic_done_q, dut.dc_done_q}, {c >= 3, 1'b0}); end
      next();
      if (c < 5) e_ms++;
    end
    idle();
    #4;
    checks++;
    if ({dut.ic_done_q, dut.dc_done_q} !== 2'b00) begin errors++; $display("FAIL split_flags_c6 got=%b exp=00", {dut.ic_done_q, dut.dc_done_q}); end
    checks++;
    if (perf_mem_stall !== (PERF ? e_ms : 32'd0)) begin errors++; $display("FAIL split_count got=%0d exp=%0d", perf_mem_stall, PERF ? e_ms : 32'd0); end
    next();
  endtask
  task test_both_resp;
    imem_read = 1'b1; dmem_req = 1'b1; imem_resp = 1'b1; dmem_resp = 1'b1;
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL both_resp got=%b exp=%b", outs, ADV); end
    next();
    idle();
    #4;
    checks++;
    if ({dut.ic_done_q, dut.dc_done_q} !== 2'b00) begin errors++; $display("FAIL both_resp_flags got=%b exp=00", {dut.ic_done_q, dut.dc_done_q}); end
    next();
  endtask
  task test_redirect_stall;
    EX_redirect = 1'b1; dmem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dmem_resp = (c == 3);
      #4;
      checks++;
      if (outs !== (c < 3 ? FRZ : RED)) begin errors++; $display("FAIL redir_stall_c%0d got=%b exp=%b", c, outs, c < 3 ? FRZ : RED); end
      next();
      if (c < 3) e_ms++; else e_rd++;
    end
    idle();
    #4;
    checks++;
    if (perf_redirect !== (PERF ? e_rd : 32'd0)) begin errors++; $display("FAIL redir_stall_count got=%0d exp=%0d", perf_redirect, PERF ? e_rd : 32'd0); end
    checks++;
    if (perf_mem_stall !== (PERF ? e_ms : 32'd0)) begin errors++; $display("FAIL redir_stall_ms got=%0d exp=%0d", perf_mem_stall, PERF ? e_ms : 32'd0); end
    next();
  endtask
  task test_async_reset;
    imem_read = 1'b1; dmem_req = 1'b1; imem_resp = 1'b1;
    next();
    imem_resp = 1'b0;
    #1;
    checks++;
    if (dut.ic_done_q !== 1'b1) begin errors++; $display("FAIL pre_reset_ic_done got=%b exp=1", dut.ic_done_q); end
    #1 rst = 1'b1;
    #1;
    e_ms = 0; e_lu = 0; e_rd = 0;
    checks++;
    if ({dut.ic_done_q, dut.dc_done_q} !== 2'b00) begin errors++; $display("FAIL async_flags got=%b exp=00", {dut.ic_done_q, dut.dc_done_q}); end
    checks++;
    if ({perf_mem_stall, perf_load_use, perf_redirect} !== 96'd0) begin errors++; $display("FAIL async_perf got=%0d/%0d/%0d exp=0/0/0", perf_mem_stall, perf_load_use, perf_redirect); end
    idle();
    #1;
    checks++;
    if (outs !== FRZ) begin errors++; $display("FAIL rst_held_outs got=%b exp=%b", outs, FRZ); end
    next();
    rst = 1'b0;
    imem_read = 1'b1;
    #3;
    checks++;
    if (outs !== FRZ) begin errors++; $display("FAIL no_stale_resp got=%b exp=%b", outs, FRZ); end
    next();
    idle();
    #4;
    checks++;
    if (outs !== ADV) begin errors++; $display("FAIL post_async_adv got=%b exp=%b", outs, ADV); end
    next();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect_priority();
    test_split_cache();
    test_both_resp();
    test_redirect_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
